// File: rtl/uart_cmd_pkg.sv
// Shared definitions for the UART command responder: frame header bytes,
// command and status codes, and the parser/sequencer state encoding.
// Optional feature macro: UART_CMD_CHECKSUM_EN (adds the CHK byte to frames).
package uart_cmd_pkg;

  localparam logic [7:0] HDR_CMD = 8'hA5;
  localparam logic [7:0] HDR_RSP = 8'h5A;

  localparam logic [7:0] CMD_WRITE = 8'h01;
  localparam logic [7:0] CMD_READ  = 8'h02;

  localparam logic [7:0] ST_OK       = 8'h00;
  localparam logic [7:0] ST_BAD_CHK  = 8'h01;
  localparam logic [7:0] ST_BAD_CMD  = 8'h02;
  localparam logic [7:0] ST_BAD_ADDR = 8'h03;

  // S_CHK is only reachable when the checksum byte is part of the frame.
  typedef enum logic [3:0] {
    S_IDLE,
    S_CMD,
    S_ADDR,
    S_DATA,
    S_CHK,
    S_EXEC,
    S_TX_HDR,
    S_TX_STAT,
    S_TX_DATA
  } state_e;

  // Frame checksum over the payload bytes.
  function automatic logic [7:0] frame_chk(input logic [7:0] cmd,
                                           input logic [7:0] addr,
                                           input logic [7:0] data);
    return cmd ^ addr ^ data;
  endfunction

endpackage

// File: rtl/uart_cmd_responder_gap_timer.sv
// Inter-byte gap timer: counts while enabled, restarts on clear, and pulses
// expire_o for one cycle when the count reaches TIMEOUT_CYCLES.
// Optional feature macro of the enclosing design: UART_CMD_CHECKSUM_EN (unused here).
module gap_timer #(
  parameter int TIMEOUT_CYCLES = 1_000_000,
  parameter int TO_BITS        = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam logic [TO_BITS-1:0] LIMIT = TO_BITS'(TIMEOUT_CYCLES);

  logic [TO_BITS-1:0] count_q, count_d;

  // A clear always wins; the counter restarts after it expires so the
  // expire output never stays high for more than one cycle.
  assign expire_o = en_i && !clr_i && (count_q == LIMIT);

  // Next count: hold at zero when disabled or cleared, wrap after expiry.
  always_comb begin
    count_d = count_q + TO_BITS'(1);
    if (clr_i || !en_i || (count_q == LIMIT)) begin
      count_d = '0;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/uart_cmd_responder.sv
// Byte-level command responder: parses host frames from the UART receiver,
// executes register reads/writes on an internal bank and returns a 3-byte
// response (0x5A, STATUS, RDATA) through the transmitter start/done handshake.
// Optional feature macro: UART_CMD_CHECKSUM_EN -- when defined the frame carries
// a trailing CHK byte (CMD^ADDR^DATA) that is verified; otherwise frames are
// 4 bytes long and a bad-checksum status is never produced.
module uart_cmd_responder
  import uart_cmd_pkg::*;
#(
  parameter int NUM_REGS       = 8,
  parameter int ADDR_BITS      = 3,
  parameter int TIMEOUT_CYCLES = 1_000_000,
  parameter int TO_BITS        = 20
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_rx_done_tick,
  input  logic [7:0]            i_rx_data,
  output logic                  o_tx_start,
  output logic [7:0]            o_tx_data,
  input  logic                  i_tx_done_tick,
  output logic [NUM_REGS*8-1:0] o_regs,
  output logic                  o_wr_tick,
  output logic [ADDR_BITS-1:0]  o_wr_addr
);

  state_e state_q, state_d;

  logic [7:0] cmd_q, cmd_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] data_q, data_d;
`ifdef UART_CMD_CHECKSUM_EN
  logic [7:0] chk_q, chk_d;
`endif
  logic [7:0] status_q, status_d;
  logic [7:0] rdata_q, rdata_d;
  logic [7:0] tx_data_q, tx_data_d;
  logic       tx_start_q, tx_start_d;

  logic [7:0]           regs_q [NUM_REGS];
  logic [ADDR_BITS-1:0] wr_addr_q;

  logic                 timer_en;
  logic                 timer_expire;
  logic                 chk_ok;
  logic                 addr_ok;
  logic                 wr_en;
  logic [7:0]           exec_status;
  logic [7:0]           exec_rdata;
  logic [ADDR_BITS-1:0] reg_idx;

  // The full address byte is range-checked; only the low bits index the bank.
  assign reg_idx = addr_q[ADDR_BITS-1:0];
  assign addr_ok = (int'(addr_q) < NUM_REGS);

`ifdef UART_CMD_CHECKSUM_EN
  assign chk_ok = (frame_chk(cmd_q, addr_q, data_q) == chk_q);
`else
  assign chk_ok = 1'b1;
`endif

  // The gap timer only runs while a frame is partially received.
  assign timer_en = state_q inside {S_CMD, S_ADDR, S_DATA, S_CHK};

  gap_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .TO_BITS       (TO_BITS)
  ) u_gap_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (i_rx_done_tick),
    .en_i    (timer_en),
    .expire_o(timer_expire)
  );

  // Command evaluation: checksum first, then command code, then address.
  always_comb begin
    exec_status = ST_OK;
    exec_rdata  = 8'h00;
    if (!chk_ok) begin
      exec_status = ST_BAD_CHK;
    end else if ((cmd_q != CMD_WRITE) && (cmd_q != CMD_READ)) begin
      exec_status = ST_BAD_CMD;
    end else if (!addr_ok) begin
      exec_status = ST_BAD_ADDR;
    end else if (cmd_q == CMD_WRITE) begin
      exec_rdata = data_q;
    end else begin
      exec_rdata = regs_q[reg_idx];
    end
  end

  assign wr_en     = (state_q == S_EXEC) && (exec_status == ST_OK) && (cmd_q == CMD_WRITE);
  assign o_wr_tick = wr_en;
  assign o_wr_addr = wr_en ? reg_idx : wr_addr_q;

  // Next-state and output logic for the frame parser and response sequencer.
  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    addr_d     = addr_q;
    data_d     = data_q;
`ifdef UART_CMD_CHECKSUM_EN
    chk_d      = chk_q;
`endif
    status_d   = status_q;
    rdata_d    = rdata_q;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (i_rx_done_tick && (i_rx_data == HDR_CMD)) begin
          state_d = S_CMD;
        end
      end
      // In the receive states an rx tick takes precedence over an expiring gap.
      S_CMD: begin
        if (i_rx_done_tick) begin
          cmd_d   = i_rx_data;
          state_d = S_ADDR;
        end else if (timer_expire) begin
          state_d = S_IDLE;
        end
      end
      S_ADDR: begin
        if (i_rx_done_tick) begin
          addr_d  = i_rx_data;
          state_d = S_DATA;
        end else if (timer_expire) begin
          state_d = S_IDLE;
        end
      end
      S_DATA: begin
        if (i_rx_done_tick) begin
          data_d  = i_rx_data;
`ifdef UART_CMD_CHECKSUM_EN
          state_d = S_CHK;
`else
          state_d = S_EXEC;
`endif
        end else if (timer_expire) begin
          state_d = S_IDLE;
        end
      end
      S_CHK: begin
`ifdef UART_CMD_CHECKSUM_EN
        if (i_rx_done_tick) begin
          chk_d   = i_rx_data;
          state_d = S_EXEC;
        end else if (timer_expire) begin
          state_d = S_IDLE;
        end
`else
        state_d = S_IDLE;
`endif
      end
      S_EXEC: begin
        status_d   = exec_status;
        rdata_d    = exec_rdata;
        tx_data_d  = HDR_RSP;
        tx_start_d = 1'b1;
        state_d    = S_TX_HDR;
      end
      S_TX_HDR: begin
        if (i_tx_done_tick) begin
          tx_data_d  = status_q;
          tx_start_d = 1'b1;
          state_d    = S_TX_STAT;
        end
      end
      S_TX_STAT: begin
        if (i_tx_done_tick) begin
          tx_data_d  = rdata_q;
          tx_start_d = 1'b1;
          state_d    = S_TX_DATA;
        end
      end
      S_TX_DATA: begin
        if (i_tx_done_tick) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // FSM, frame fields and transmit output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cmd_q      <= 8'h00;
      addr_q     <= 8'h00;
      data_q     <= 8'h00;
`ifdef UART_CMD_CHECKSUM_EN
      chk_q      <= 8'h00;
`endif
      status_q   <= 8'h00;
      rdata_q    <= 8'h00;
      tx_data_q  <= 8'h00;
      tx_start_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
`ifdef UART_CMD_CHECKSUM_EN
      chk_q      <= chk_d;
`endif
      status_q   <= status_d;
      rdata_q    <= rdata_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
    end
  end

  // Register bank and last-write address; updated only by a successful write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= 8'h00;
      end
      wr_addr_q <= '0;
    end else if (wr_en) begin
      regs_q[reg_idx] <= data_q;
      wr_addr_q       <= reg_idx;
    end
  end

  assign o_tx_start = tx_start_q;
  assign o_tx_data  = tx_data_q;

  // Flatten the bank: register k occupies bits [8k+7:8k].
  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_regs_out
    assign o_regs[gi*8 +: 8] = regs_q[gi];
  end

endmodule

// File: tb/tb_uart_cmd_responder.sv
// Directed self-checking bench for uart_cmd_responder. Uses a short gap
// timeout so the timeout case stays brief. Honours UART_CMD_CHECKSUM_EN to
// choose 4- or 5-byte frames.
module tb_uart_cmd_responder;

  localparam int NUM_REGS  = 8;
  localparam int ADDR_BITS = 3;
  localparam int TOC       = 40;
  localparam int TOB       = 8;
`ifdef UART_CMD_CHECKSUM_EN
  localparam int NB = 5;
`else
  localparam int NB = 4;
`endif

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  rx_tick = 1'b0;
  logic [7:0]            rx_data = 8'h00;
  logic                  tx_start;
  logic [7:0]            tx_data;
  logic                  tx_done = 1'b0;
  logic [NUM_REGS*8-1:0] regs;
  logic                  wr_tick;
  logic [ADDR_BITS-1:0]  wr_addr;

  int tests = 0;
  int fails = 0;
  int wr_count = 0;
  int start_count = 0;
  logic [ADDR_BITS-1:0] last_wr_addr = '0;

  uart_cmd_responder #(
    .NUM_REGS      (NUM_REGS),
    .ADDR_BITS     (ADDR_BITS),
    .TIMEOUT_CYCLES(TOC),
    .TO_BITS       (TOB)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_rx_done_tick(rx_tick),
    .i_rx_data     (rx_data),
    .o_tx_start    (tx_start),
    .o_tx_data     (tx_data),
    .i_tx_done_tick(tx_done),
    .o_regs        (regs),
    .o_wr_tick     (wr_tick),
    .o_wr_addr     (wr_addr)
  );

  always #5 clk = ~clk;

  // Observe write ticks and transmit starts mid-cycle.
  always @(negedge clk) begin
    if (wr_tick) begin
      wr_count     <= wr_count + 1;
      last_wr_addr <= wr_addr;
    end
    if (tx_start) begin
      start_count <= start_count + 1;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next falling edge.
  task automatic cyc(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_tick = 1'b1;
    cyc(1);
    rx_tick = 1'b0;
  endtask

  task automatic send_frame(input logic [39:0] f);
    for (int i = 0; i < NB; i++) begin
      if (i != 0) cyc(2);
      send_byte(f[39-8*i -: 8]);
    end
  endtask

  // Collect the three response bytes, returning a done tick after each one.
  task automatic get_resp(input string tag, output logic [23:0] resp);
    resp = '0;
    for (int i = 0; i < 3; i++) begin
      int k;
      k = 0;
      while (!tx_start && k < 50) begin
        cyc(1);
        k++;
      end
      check_eq({tag, "_lat"}, k, (i == 0) ? 1 : 0);
      resp[23-8*i -: 8] = tx_data;
      cyc(2);
      tx_done = 1'b1;
      cyc(1);
      tx_done = 1'b0;
    end
  endtask

  task automatic run_txn(input string tag, input logic [39:0] f,
                         input logic [23:0] exp, input int exp_wr);
    logic [23:0] resp;
    int w0;
    w0 = wr_count;
    send_frame(f);
    get_resp(tag, resp);
    check_eq({tag, "_resp"}, resp, exp);
    check_eq({tag, "_wrcnt"}, wr_count - w0, exp_wr);
    $display("[TB] %s frame=%h resp=%h writes=%0d", tag, f, resp, wr_count - w0);
    cyc(3);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0;
    logic [23:0] dummy;

    // Reset state.
    cyc(3);
    check_eq("rst_tx_start", tx_start, 1'b0);
    check_eq("rst_tx_data", tx_data, 8'h00);
    check_eq("rst_regs_lo", regs[31:0], 32'h0);
    check_eq("rst_regs_hi", regs[63:32], 32'h0);
    check_eq("rst_wr_tick", wr_tick, 1'b0);
    check_eq("rst_wr_addr", wr_addr, 3'd0);
    rst_n = 1'b1;
    cyc(2);

    // Garbage bytes in IDLE are dropped, then a write to reg2.
    send_byte(8'h00);
    cyc(2);
    send_byte(8'hFF);
    cyc(2);
    run_txn("write_r2", 40'hA5_01_02_3C_3F, 24'h5A_00_3C, 1);
    check_eq("write_r2_addr", last_wr_addr, 3'd2);
    check_eq("write_r2_reg", regs[8*2 +: 8], 8'h3C);

    // Read back reg2.
    run_txn("read_r2", 40'hA5_02_02_00_00, 24'h5A_00_3C, 0);

`ifdef UART_CMD_CHECKSUM_EN
    // Bad checksum: no write.
    run_txn("bad_chk", 40'hA5_01_01_55_00, 24'h5A_01_00, 0);
    check_eq("bad_chk_reg1", regs[8*1 +: 8], 8'h00);
    // Bad address with a correct checksum (01^09^11 = 19).
    run_txn("bad_addr", 40'hA5_01_09_11_19, 24'h5A_03_00, 0);
`else
    run_txn("bad_addr", 40'hA5_01_09_11_18, 24'h5A_03_00, 0);
`endif
    run_txn("bad_cmd", 40'hA5_07_00_00_07, 24'h5A_02_00, 0);

    // Address boundaries: last valid and first invalid.
    run_txn("write_r7", 40'hA5_01_07_AA_AC, 24'h5A_00_AA, 1);
    check_eq("write_r7_addr", last_wr_addr, 3'd7);
    check_eq("write_r7_reg", regs[8*7 +: 8], 8'hAA);
    run_txn("read_r8", 40'hA5_02_08_00_0A, 24'h5A_03_00, 0);

    // Timeout: partial frame is discarded with no response.
    s0 = start_count;
    send_byte(8'hA5);
    cyc(2);
    send_byte(8'h01);
    cyc(TOC + 10);
    check_eq("timeout_silent", start_count - s0, 0);
    run_txn("after_timeout", 40'hA5_02_00_00_02, 24'h5A_00_00, 0);
    cyc(20);
    check_eq("timeout_one_resp", start_count - s0, 3);

    // Reset during TX_STAT aborts the response and clears the bank.
    send_frame(40'hA5_01_03_77_75);
    begin
      int k;
      k = 0;
      while (!tx_start && k < 50) begin
        cyc(1);
        k++;
      end
      check_eq("rst_mid_hdr", tx_data, 8'h5A);
    end
    cyc(2);
    tx_done = 1'b1;
    cyc(1);
    tx_done = 1'b0;
    check_eq("rst_mid_stat_start", tx_start, 1'b1);
    rst_n = 1'b0;
    #1;
    check_eq("rst_mid_tx_start", tx_start, 1'b0);
    check_eq("rst_mid_tx_data", tx_data, 8'h00);
    check_eq("rst_mid_regs_lo", regs[31:0], 32'h0);
    check_eq("rst_mid_regs_hi", regs[63:32], 32'h0);
    cyc(2);
    rst_n = 1'b1;
    s0 = start_count;
    cyc(20);
    check_eq("rst_mid_no_resp", start_count - s0, 0);
    $display("[TB] reset_mid_tx aborted response");
    run_txn("read_r3_after_rst", 40'hA5_02_03_00_01, 24'h5A_00_00, 0);

    dummy = '0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
